level_fifo: RTL and testbench
=============================

LEVEL_FIFO -- requirements
Module: level_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of storage entries; any integer 2..256, not restricted to powers of two.
REQ-003 SHALL have parameter ALMOST_FULL, default 12, threshold for almostFull (1..DEPTH).
REQ-004 SHALL have parameter ALMOST_EMPTY, default 2, threshold for almostEmpty (0..DEPTH-1).
REQ-005 SHALL have parameter FWFT, default 0: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have ports: clk  in  1  single clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: writeReq  in  1  write request; dataIn  in  DATA_WIDTH  write data; writeAck  out  1  write accepted.
REQ-008 SHALL have ports: readReq  in  1  read request; readAck  out  1  read accepted; dataOut  out  DATA_WIDTH  read data.
REQ-009 SHALL have ports: empty, full, almostEmpty, almostFull  out  1  status flags; level  out  clog2(DEPTH+1)  occupancy.
REQ-010 SHALL have ports: overflow, underflow  out  1  sticky error flags; clearErr  in  1  synchronous error clear.

Function
REQ-011 SHALL store up to DEPTH words, all entries usable; full means level == DEPTH.
REQ-012 SHALL wrap read and write pointers from DEPTH-1 to 0 (explicit compare, not bit truncation).
REQ-013 SHALL derive empty = (level == 0), full = (level == DEPTH), almostFull = (level >= ALMOST_FULL), almostEmpty = (level <= ALMOST_EMPTY), all from the registered level.
REQ-014 SHALL accept a read (acc_rd) when readReq && !empty.
REQ-015 SHALL accept a write (acc_wr) when writeReq && (!full || acc_rd); writing while full with a simultaneous accepted read is legal.
REQ-016 SHALL update level at the clock edge: +1 on acc_wr only, -1 on acc_rd only, unchanged on both or neither.
REQ-017 SHALL, when empty with writeReq and readReq together, accept the write, reject the read, and set underflow.
REQ-018 SHALL drive writeAck = 1 for exactly one cycle after each accepted write, else 0.
REQ-019 SHALL drive readAck = 1 for exactly one cycle after each accepted read, else 0.
REQ-020 SHALL (FWFT=0) load dataOut with the head word at the accepting edge and hold it until the next accepted read.
REQ-021 SHALL (FWFT=1) drive dataOut with the head word whenever !empty, with zero latency; a word written into an empty FIFO appears on dataOut the cycle after its write edge; dataOut is don't-care while empty.
REQ-022 SHALL set overflow on writeReq && !acc_wr, and set underflow on readReq && !acc_rd.
REQ-023 SHALL clear both sticky flags on clearErr; a new error in the same cycle takes priority and leaves its flag set.
REQ-024 SHALL retain stored data and order across any request pattern; rejected requests change no state other than the error flags.

Reset
REQ-025 SHALL, on rst_n low, immediately and without a clock: clear pointers, set level = 0, empty = 1, almostEmpty = 1, full = 0, almostFull = 0, readAck = 0, writeAck = 0, dataOut = 0, overflow = 0, underflow = 0.
REQ-026 SHALL NOT reset memory contents.
REQ-027 SHALL hold reset state while rst_n is low, and accept requests from the first rising edge after rst_n goes high.
REQ-028 SHALL discard any transfer in progress when reset is asserted mid-operation; no ack is issued for it.

Verification (DATA_WIDTH=16, DEPTH=5, ALMOST_FULL=4, ALMOST_EMPTY=1)
REQ-029 Fill: write 0x0001..0x0005 -> five writeAck pulses, level 1..5, almostFull at level 4, full at level 5; sixth write -> writeAck=0, overflow=1, level=5.
REQ-030 Drain (FWFT=0): five reads -> readAck each, dataOut 0x0001..0x0005 in order, empty=1; sixth read -> readAck=0, underflow=1, dataOut holds 0x0005.
REQ-031 Wrap: write and read 13 words 0x0100..0x010C interleaved, level never above 3 -> output order exact, pointers wrap past index 4 with no loss.
REQ-032 Simultaneous: at full, writeReq and readReq together -> both acked, level stays 5, no overflow; at empty, both requests -> write acked, read rejected, underflow=1, level=1.
REQ-033 Errors and reset: clearErr with no new error -> flags 0; clearErr with overflow in the same cycle -> overflow=1; rst_n pulsed low between edges with level=3 -> all outputs at reset values before the next edge.
REQ-034 FWFT=1: write 0x00AA into an empty FIFO -> dataOut=0x00AA and empty=0 the next cycle; readReq -> readAck=1, level=0.

Source files
------------

// File: rtl/level_fifo.sv
// Synchronous single-clock FIFO with occupancy level, threshold flags and sticky
// error flags. Supports non-power-of-two depth and optional first-word-fall-through.
module level_fifo #(
    parameter int DATA_WIDTH   = 16,
    parameter int DEPTH        = 16,
    parameter int ALMOST_FULL  = 12,
    parameter int ALMOST_EMPTY = 2,
    parameter int FWFT         = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         writeReq,
    input  logic [DATA_WIDTH-1:0]        dataIn,
    output logic                         writeAck,
    input  logic                         readReq,
    output logic                         readAck,
    output logic [DATA_WIDTH-1:0]        dataOut,
    output logic                         empty,
    output logic                         full,
    output logic                         almostEmpty,
    output logic                         almostFull,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         clearErr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE_P    = AW'(1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(ALMOST_FULL);
    localparam logic [LW-1:0] AE_LVL   = LW'(ALMOST_EMPTY);
    localparam logic [LW-1:0] ONE_L    = LW'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_wack;
    logic                  r_rack;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_acc_rd;
    logic                  w_acc_wr;
    logic [AW-1:0]         w_wr_ptr_nxt;
    logic [AW-1:0]         w_rd_ptr_nxt;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == FULL_LVL);
    assign w_acc_rd = readReq && !w_empty;
    // A read in the same edge frees the slot, so a full FIFO may still take a write.
    assign w_acc_wr = writeReq && (!w_full || w_acc_rd);

    // Explicit wrap so that non-power-of-two depths never index past DEPTH-1.
    assign w_wr_ptr_nxt = (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + ONE_P;
    assign w_rd_ptr_nxt = (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + ONE_P;

    assign w_head = r_mem[r_rd_ptr];

    // Storage array carries no reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (rst_n && w_acc_wr) begin
            r_mem[r_wr_ptr] <= dataIn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_wack   <= 1'b0;
            r_rack   <= 1'b0;
        end else begin
            r_wack <= w_acc_wr;
            r_rack <= w_acc_rd;
            if (w_acc_wr) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_acc_rd) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            if (w_acc_wr && !w_acc_rd) begin
                r_level <= r_level + ONE_L;
            end else if (w_acc_rd && !w_acc_wr) begin
                r_level <= r_level - ONE_L;
            end
        end
    end

    // A fresh error outranks clearErr in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (writeReq && !w_acc_wr) begin
                r_ovf <= 1'b1;
            end else if (clearErr) begin
                r_ovf <= 1'b0;
            end
            if (readReq && !w_acc_rd) begin
                r_udf <= 1'b1;
            end else if (clearErr) begin
                r_udf <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shows combinationally; forced to zero while empty so reset reads 0.
            assign dataOut = w_empty ? '0 : w_head;
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_dout;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout <= '0;
                end else if (w_acc_rd) begin
                    r_dout <= w_head;
                end
            end

            assign dataOut = r_dout;
        end
    endgenerate

    assign writeAck    = r_wack;
    assign readAck     = r_rack;
    assign level       = r_level;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almostFull  = (r_level >= AF_LVL);
    assign almostEmpty = (r_level <= AE_LVL);
    assign overflow    = r_ovf;
    assign underflow   = r_udf;

endmodule

// File: tb/tb_level_fifo.sv
// Directed bench for level_fifo: DEPTH=5, ALMOST_FULL=4, ALMOST_EMPTY=1, one
// registered-read instance and one first-word-fall-through instance.
module tb_level_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        writeReq = 1'b0, readReq = 1'b0, clearErr = 1'b0;
    logic [15:0] dataIn = '0;
    logic        writeAck, readAck, empty, full, almostEmpty, almostFull, overflow, underflow;
    logic [15:0] dataOut;
    logic [2:0]  level;

    logic        writeReq1 = 1'b0, readReq1 = 1'b0, clearErr1 = 1'b0;
    logic [15:0] dataIn1 = '0;
    logic        writeAck1, readAck1, empty1, full1, almostEmpty1, almostFull1, overflow1, underflow1;
    logic [15:0] dataOut1;
    logic [2:0]  level1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    level_fifo #(.DATA_WIDTH(16), .DEPTH(5), .ALMOST_FULL(4), .ALMOST_EMPTY(1), .FWFT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .writeReq(writeReq), .dataIn(dataIn), .writeAck(writeAck),
        .readReq(readReq), .readAck(readAck), .dataOut(dataOut),
        .empty(empty), .full(full), .almostEmpty(almostEmpty), .almostFull(almostFull),
        .level(level), .overflow(overflow), .underflow(underflow), .clearErr(clearErr)
    );

    level_fifo #(.DATA_WIDTH(16), .DEPTH(5), .ALMOST_FULL(4), .ALMOST_EMPTY(1), .FWFT(1)) dut_fwft (
        .clk(clk), .rst_n(rst_n),
        .writeReq(writeReq1), .dataIn(dataIn1), .writeAck(writeAck1),
        .readReq(readReq1), .readAck(readAck1), .dataOut(dataOut1),
        .empty(empty1), .full(full1), .almostEmpty(almostEmpty1), .almostFull(almostFull1),
        .level(level1), .overflow(overflow1), .underflow(underflow1), .clearErr(clearErr1)
    );

    typedef struct {
        logic        wr, rd, clr;
        logic [15:0] din;
        logic        wack, rack;
        logic [15:0] dout;
        logic [2:0]  lvl;
        logic        e, f, ae, af, ovf, udf;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic wack, input logic rack,
                           input logic [15:0] dout, input logic [2:0] lvl,
                           input logic e, input logic f, input logic ae, input logic af,
                           input logic ovf, input logic udf);
        chk({tag, ".writeAck"}, writeAck, wack);
        chk({tag, ".readAck"}, readAck, rack);
        chk({tag, ".dataOut"}, dataOut, dout);
        chk({tag, ".level"}, level, lvl);
        chk({tag, ".empty"}, empty, e);
        chk({tag, ".full"}, full, f);
        chk({tag, ".almostEmpty"}, almostEmpty, ae);
        chk({tag, ".almostFull"}, almostFull, af);
        chk({tag, ".overflow"}, overflow, ovf);
        chk({tag, ".underflow"}, underflow, udf);
    endtask

    task automatic cyc(input logic wr, input logic rd, input logic clr, input logic [15:0] d);
        @(negedge clk);
        writeReq = wr; readReq = rd; clearErr = clr; dataIn = d;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic wr, input logic rd, input logic clr, input logic [15:0] din,
                                input logic wack, input logic rack, input logic [15:0] dout,
                                input logic [2:0] lvl, input logic e, input logic f,
                                input logic ae, input logic af, input logic ovf, input logic udf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
        v.wack = wack; v.rack = rack; v.dout = dout; v.lvl = lvl;
        v.e = e; v.f = f; v.ae = ae; v.af = af; v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    initial begin
        logic [15:0] q[$];
        logic [15:0] exp_d;
        int          mlvl;
        int          wi;
        int          rcount;
        logic        a_rd, a_wr, do_wr, do_rd;

        //           wr rd cl din      wack rack dout     lvl e f ae af ov ud
        vecs[0]  = mk(1, 0, 0, 16'h0001, 1, 0, 16'h0000, 3'd1, 0, 0, 1, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 16'h0002, 1, 0, 16'h0000, 3'd2, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 16'h0003, 1, 0, 16'h0000, 3'd3, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 16'h0004, 1, 0, 16'h0000, 3'd4, 0, 0, 0, 1, 0, 0);
        vecs[4]  = mk(1, 0, 0, 16'h0005, 1, 0, 16'h0000, 3'd5, 0, 1, 0, 1, 0, 0);
        vecs[5]  = mk(1, 0, 0, 16'h0006, 0, 0, 16'h0000, 3'd5, 0, 1, 0, 1, 1, 0);
        vecs[6]  = mk(0, 0, 1, 16'h0000, 0, 0, 16'h0000, 3'd5, 0, 1, 0, 1, 0, 0);
        vecs[7]  = mk(0, 1, 0, 16'h0000, 0, 1, 16'h0001, 3'd4, 0, 0, 0, 1, 0, 0);
        vecs[8]  = mk(0, 1, 0, 16'h0000, 0, 1, 16'h0002, 3'd3, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 1, 0, 16'h0000, 0, 1, 16'h0003, 3'd2, 0, 0, 0, 0, 0, 0);
        vecs[10] = mk(0, 1, 0, 16'h0000, 0, 1, 16'h0004, 3'd1, 0, 0, 1, 0, 0, 0);
        vecs[11] = mk(0, 1, 0, 16'h0000, 0, 1, 16'h0005, 3'd0, 1, 0, 1, 0, 0, 0);
        vecs[12] = mk(0, 1, 0, 16'h0000, 0, 0, 16'h0005, 3'd0, 1, 0, 1, 0, 0, 1);
        vecs[13] = mk(0, 0, 1, 16'h0000, 0, 0, 16'h0005, 3'd0, 1, 0, 1, 0, 0, 0);
        vecs[14] = mk(1, 1, 0, 16'h0077, 1, 0, 16'h0005, 3'd1, 0, 0, 1, 0, 0, 1);
        vecs[15] = mk(0, 0, 1, 16'h0000, 0, 0, 16'h0005, 3'd1, 0, 0, 1, 0, 0, 0);
        vecs[16] = mk(0, 1, 0, 16'h0000, 0, 1, 16'h0077, 3'd0, 1, 0, 1, 0, 0, 0);

        // Reset held low across edges.
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 16'h0000, 3'd0, 1, 0, 1, 0, 0, 0);
        chk("reset.fwft_dataOut", dataOut1, 16'h0000);
        chk("reset.fwft_empty", empty1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            cyc(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
            chk_all($sformatf("vec%0d", i), vecs[i].wack, vecs[i].rack, vecs[i].dout, vecs[i].lvl,
                    vecs[i].e, vecs[i].f, vecs[i].ae, vecs[i].af, vecs[i].ovf, vecs[i].udf);
        end

        // Simultaneous read and write while full, then clearErr racing a new overflow.
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 16'h0201 + 16'(i));
        end
        chk("fill2.full", full, 1'b1);
        cyc(1, 1, 0, 16'h0206);
        chk("fullrw.writeAck", writeAck, 1'b1);
        chk("fullrw.readAck", readAck, 1'b1);
        chk("fullrw.dataOut", dataOut, 16'h0201);
        chk("fullrw.level", level, 3'd5);
        chk("fullrw.overflow", overflow, 1'b0);
        cyc(1, 0, 1, 16'h0207);
        chk("clr_vs_ovf.overflow", overflow, 1'b1);
        chk("clr_vs_ovf.writeAck", writeAck, 1'b0);
        chk("clr_vs_ovf.level", level, 3'd5);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 16'h0000);
            chk($sformatf("drain2_%0d.dataOut", i), dataOut, 16'h0202 + 16'(i));
        end
        cyc(0, 0, 1, 16'h0000);
        chk("clr.overflow", overflow, 1'b0);
        chk("clr.underflow", underflow, 1'b0);

        // Interleaved stream of 13 words; pointers wrap several times.
        mlvl = 0; wi = 0; rcount = 0;
        for (int step = 0; step < 40 && rcount < 13; step++) begin
            do_wr = (wi < 13) && (mlvl < 3);
            do_rd = (mlvl > 0);
            a_rd  = do_rd && (mlvl > 0);
            a_wr  = do_wr && ((mlvl < 5) || a_rd);
            exp_d = 16'h0;
            if (a_rd) exp_d = q.pop_front();
            if (a_wr) begin
                q.push_back(16'h0100 + 16'(wi));
            end
            cyc(do_wr, do_rd, 0, 16'h0100 + 16'(wi));
            if (a_wr) wi++;
            if (a_wr && !a_rd) mlvl++;
            if (a_rd && !a_wr) mlvl--;
            chk($sformatf("wrap%0d.readAck", step), readAck, a_rd);
            chk($sformatf("wrap%0d.writeAck", step), writeAck, a_wr);
            chk($sformatf("wrap%0d.level", step), level, 3'(mlvl));
            if (a_rd) begin
                chk($sformatf("wrap%0d.dataOut", step), dataOut, exp_d);
                rcount++;
            end
        end
        chk("wrap.count", rcount, 13);

        // Asynchronous reset between edges with level 3 and a write pending.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 16'h0300 + 16'(i));
        end
        chk("prerst.level", level, 3'd3);
        @(negedge clk);
        writeReq = 1'b1; readReq = 1'b0; clearErr = 1'b0; dataIn = 16'h03FF;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 16'h0000, 3'd0, 1, 0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("rst_hold.writeAck", writeAck, 1'b0);
        chk("rst_hold.level", level, 3'd0);
        @(negedge clk);
        writeReq = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst.writeAck", writeAck, 1'b0);
        chk("post_rst.empty", empty, 1'b1);
        cyc(1, 0, 0, 16'h0401);
        chk("post_rst_wr.writeAck", writeAck, 1'b1);
        chk("post_rst_wr.level", level, 3'd1);
        cyc(0, 1, 0, 16'h0000);
        chk("post_rst_rd.dataOut", dataOut, 16'h0401);
        @(negedge clk);
        readReq = 1'b0;

        // First-word-fall-through instance.
        @(negedge clk);
        writeReq1 = 1'b1; dataIn1 = 16'h00AA;
        @(posedge clk);
        #1;
        chk("fwft.dataOut", dataOut1, 16'h00AA);
        chk("fwft.empty", empty1, 1'b0);
        chk("fwft.writeAck", writeAck1, 1'b1);
        @(negedge clk);
        writeReq1 = 1'b0; readReq1 = 1'b1;
        @(posedge clk);
        #1;
        chk("fwft_rd.readAck", readAck1, 1'b1);
        chk("fwft_rd.level", level1, 3'd0);
        chk("fwft_rd.empty", empty1, 1'b1);
        @(negedge clk);
        readReq1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
